alu_muldiv_seq: RTL and testbench
=================================

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-002 Parameter: WIDTH, 32, operand/result width (SHALL be >= 2).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op_sel  input  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-007 a_in  input  WIDTH  multiplicand / dividend, captured with start.
REQ-008 b_in  input  WIDTH  multiplier / divisor, captured with start.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 hi  output  WIDTH  product upper half / remainder.
REQ-012 lo  output  WIDTH  product lower half / quotient.
REQ-013 div_by_zero  output  1  set with done when divide had b_in = 0.
REQ-014 alu_op  output  3  op to shared ALU: 3'b010 add, 3'b110 subtract.
REQ-015 alu_a, alu_b  output  WIDTH  ALU operands.
REQ-016 alu_result  input  WIDTH; alu_cout  input  1  combinational ALU response, same cycle.

Function
REQ-017 FSM states SHALL be IDLE, MUL, DIV, FIN; FIN lasts exactly one cycle then returns to IDLE.
REQ-018 IDLE + start: capture operands, clear div_by_zero, counter = WIDTH, go MUL (op_sel=0) or DIV (op_sel=1); busy high next cycle.
REQ-019 MUL init: hi = 0, lo = b_in, mcand = a_in.
REQ-020 MUL step: alu_op = add, alu_a = hi, alu_b = lo[0] ? mcand : 0; register {hi,lo} <= {alu_cout, alu_result, lo[WIDTH-1:1]}.
REQ-021 DIV init: hi = 0, lo = a_in, divisor = b_in.
REQ-022 DIV step: alu_op = subtract, alu_a = {hi[WIDTH-2:0], lo[WIDTH-1]}, alu_b = divisor; if (hi[WIDTH-1] | alu_cout) then hi <= alu_result, lo <= {lo[WIDTH-2:0],1}, else hi <= alu_a, lo <= {lo[WIDTH-2:0],0}.
REQ-023 alu_cout = 1 SHALL be interpreted as "no borrow" for subtract.
REQ-024 Each MUL/DIV cycle decrements the counter; after the step with counter = 1 the FSM SHALL go to FIN.
REQ-025 Latency: start accepted at edge N; done high during cycle N+WIDTH+1; busy low in that same cycle.
REQ-026 DIV with b_in = 0: skip iterations, go FIN next cycle; hi = a_in, lo = all ones, div_by_zero = 1 (latency 2).
REQ-027 done SHALL be asserted only in FIN; hi, lo, div_by_zero SHALL hold until the next accepted start.
REQ-028 start while busy or in FIN SHALL be ignored; start in IDLE during the cycle after FIN SHALL be accepted.
REQ-029 In IDLE and FIN, alu_op = 3'b010, alu_a = 0, alu_b = 0.
REQ-030 Operand changes on a_in/b_in after capture SHALL not affect the running operation.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0, counter = 0.
REQ-032 Reset asserted mid-operation SHALL abort it; no done pulse is produced for the aborted operation.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-034 MUL 32'd7 x 32'd6 -> done at cycle 33, hi = 0, lo = 32'd42, div_by_zero = 0.
REQ-035 MUL 32'hFFFF_FFFF x 32'hFFFF_FFFF -> hi = 32'hFFFF_FFFE, lo = 32'h0000_0001.
REQ-036 DIV 32'd100 / 32'd7 -> lo = 32'd14, hi = 32'd2; DIV 32'hFFFF_FFFF / 32'h8000_0000 -> lo = 1, hi = 32'h7FFF_FFFF.
REQ-037 DIV 32'd5 / 0 -> done at cycle 2, div_by_zero = 1, hi = 32'd5, lo = 32'hFFFF_FFFF.
REQ-038 start pulsed at cycle 10 of a MUL -> ignored, single done, result unchanged; back-to-back start right after FIN -> accepted.
REQ-039 rst_n low at cycle 15 of a DIV -> all outputs 0 asynchronously, no done; fresh MUL 3 x 3 afterwards -> lo = 32'd9.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: sequential unsigned shift-add multiply and restoring divide
// that borrows an external combinational adder/subtractor one step per cycle.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             busy_q, done_q, dbz_q;
  logic             take_d, last_d;
  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  always_comb begin
    alu_op = state_q == DIV ? 3'b110 : 3'b010;
    alu_a  = state_q == MUL ? hi_q :
             state_q == DIV ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : '0;
    alu_b  = state_q == MUL ? (lo_q[0] ? opnd_q : '0) :
             state_q == DIV ? opnd_q : '0;
    // a set top bit means the shifted remainder already exceeds any divisor
    take_d = hi_q[WIDTH-1] | alu_cout;
    last_d = cnt_q == CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= op_sel ? DIV : MUL;
          cnt_q   <= CW'(WIDTH);
          hi_q    <= '0;
          lo_q    <= op_sel ? a_in : b_in;
          opnd_q  <= op_sel ? b_in : a_in;
          busy_q  <= 1'b1;
          dbz_q   <= 1'b0;
        end
        MUL: begin
          hi_q  <= {alu_cout, alu_result[WIDTH-1:1]};
          lo_q  <= {alu_result[0], lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q - CW'(1);
          if (last_d) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DIV: if (opnd_q == '0) begin
          state_q <= FIN;
          hi_q    <= lo_q;
          lo_q    <= '1;
          cnt_q   <= '0;
          dbz_q   <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          hi_q  <= take_d ? alu_result : alu_a;
          lo_q  <= {lo_q[WIDTH-2:0], take_d};
          cnt_q <= cnt_q - CW'(1);
          if (last_d) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed vector table plus start-while-busy, back-to-back
// and mid-operation reset sequences against an ideal adder/subtractor model.
module tb_alu_muldiv_seq;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_sel = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic busy, done, div_by_zero, alu_cout;
  logic [W-1:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic [W:0] sum;
  int total = 0, bad = 0;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // carry out of a + ~b + 1 is 1 exactly when no borrow occurs
  always_comb
    sum = alu_op == 3'b110 ? {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1
                           : {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = sum[W-1:0];
  assign alu_cout   = sum[W];

  typedef struct {
    logic op; logic [W-1:0] a, b, hi, lo; logic dbz; int lat;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; op_sel = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; a_in = ~a; b_in = ~b ^ 32'h5A5A_0001;
    chk("busy_after_accept", busy, 1'b1);
    wait_done(lat);
  endtask

  initial begin
    int lat, ndone;
    v[0] = '{1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33};
    v[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 33};
    v[2] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
    v[3] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 33};
    v[4] = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2};
    v[5] = '{1'b0, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, 33};
    v[6] = '{1'b1, 32'd7, 32'd9, 32'd7, 32'd0, 1'b0, 33};
    v[7] = '{1'b0, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0, 33};
    v[8] = '{1'b1, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'hDEAD_BEEF, 1'b0, 33};
    v[9] = '{1'b1, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 33};

    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_dbz", div_by_zero, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("idle_alu", {alu_op, alu_a, alu_b}, {3'b010, 64'd0});

    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      chk($sformatf("v%0d_hi", i), hi, v[i].hi);
      chk($sformatf("v%0d_lo", i), lo, v[i].lo);
      chk($sformatf("v%0d_dbz", i), div_by_zero, v[i].dbz);
      chk($sformatf("v%0d_fin_alu", i), {alu_op, alu_a, alu_b}, {3'b010, 64'd0});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
      chk($sformatf("v%0d_hold", i), {hi, lo, 31'd0, div_by_zero}, {v[i].hi, v[i].lo, 31'd0, v[i].dbz});
    end

    // start while busy is ignored: exactly one done, MUL result unchanged
    @(negedge clk);
    start = 1'b1; op_sel = 1'b0; a_in = 32'd3; b_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c < 45; c++) begin
      if (c == 10) begin
        start = 1'b1; op_sel = 1'b1; a_in = 32'd77; b_in = 32'd0;
      end
      if (c == 11) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("busy_start_lat", c + 1, 33);
        chk("busy_start_lo", lo, 32'd15);
        chk("busy_start_hi", hi, 32'd0);
        if (c < 44) begin
          // hold start through FIN (ignored) into the following IDLE cycle
          start = 1'b1; op_sel = 1'b0; a_in = 32'd4; b_in = 32'd4;
          @(posedge clk); #1;
          chk("fin_start_ignored", {done, busy}, 2'b00);
          @(posedge clk); #1;
          start = 1'b0;
          chk("b2b_accepted", busy, 1'b1);
          wait_done(lat);
          chk("b2b_latency", lat, 33);
          chk("b2b_lo", lo, 32'd16);
          break;
        end
      end
    end
    chk("single_done", ndone, 1);

    // asynchronous reset mid-DIV aborts without done
    @(negedge clk);
    start = 1'b1; op_sel = 1'b1; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, div_by_zero, hi, lo}, '0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    rst_n = 1'b1;
    run_op(1'b0, 32'd3, 32'd3, lat);
    chk("post_reset_lat", lat, 33);
    chk("post_reset_lo", lo, 32'd9);
    chk("post_reset_hi", hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
